// File: rtl/div_32_if.sv
// Start/operand/result bundle between the execute-stage mult/div unit and the
// 32-bit multicycle divider.
interface div_32_if;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        data_busy;

    modport master (
        output ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, data_busy
    );

    modport slave (
        input  ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, data_busy
    );
endinterface

// File: rtl/div_32.sv
// 32-bit signed divider: 32-step non-restoring shift/subtract on magnitudes,
// sign fix-up afterwards, fixed 34-clock start-to-strobe latency.
module div_32 (
    input  logic     clock,
    input  logic     reset_n,
    div_32_if.slave  bus
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t                   state;
    logic [4:0]               count;
    logic [DATA_W-1:0]        result;
    logic                     exception;
    logic                     resultrdy;
    logic                     busy;

    logic signed [DATA_W:0]   rem;
    logic signed [DATA_W:0]   absb;
    logic [DATA_W-1:0]        dvd;
    logic [DATA_W-1:0]        quo;
    logic                     sign;
    logic                     bzero;

    logic signed [DATA_W:0]   rem_sh;
    logic signed [DATA_W:0]   rem_nxt;

    // Magnitude of a two's-complement value; |-2^31| lands as 0x80000000 unsigned.
    function automatic logic [DATA_W-1:0] f_mag(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction

    // Quotient sign restore with natural two's-complement wrap.
    function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] q);
        return -q;
    endfunction

    always_comb begin
        rem_sh = $signed({rem[DATA_W-1:0], dvd[DATA_W-1]});
        if (!rem[DATA_W])
            rem_nxt = rem_sh - absb;
        else
            rem_nxt = rem_sh + absb;
    end

    always_ff @(posedge clock) begin
        if (bus.ctrl_DIV) begin
            dvd   <= f_mag(bus.data_operandA);
            absb  <= $signed({1'b0, f_mag(bus.data_operandB)});
            sign  <= bus.data_operandA[DATA_W-1] ^ bus.data_operandB[DATA_W-1];
            bzero <= (bus.data_operandB == '0);
            rem   <= '0;
            quo   <= '0;
        end else if (state == RUN) begin
            rem <= rem_nxt;
            dvd <= {dvd[DATA_W-2:0], 1'b0};
            quo <= {quo[DATA_W-2:0], ~rem_nxt[DATA_W]};
        end
    end

    // A start edge wins over every state, so an in-flight op is silently dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            result    <= '0;
            exception <= 1'b0;
            resultrdy <= 1'b0;
            busy      <= 1'b0;
        end else if (bus.ctrl_DIV) begin
            state     <= RUN;
            count     <= '0;
            busy      <= 1'b1;
            resultrdy <= 1'b0;
        end else begin
            case (state)
                IDLE: resultrdy <= 1'b0;
                RUN: begin
                    count <= count + 5'd1;
                    if (count == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    result    <= bzero ? '0 : (sign ? f_neg(quo) : quo);
                    exception <= bzero;
                    state     <= DONE;
                end
                DONE: begin
                    resultrdy <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = result;
    assign bus.data_exception = exception;
    assign bus.data_resultRDY = resultrdy;
    assign bus.data_busy      = busy;
endmodule

// File: tb/tb_div_32.sv
// Scoreboard bench for div_32: directed sign/edge/restart/reset cases plus
// random back-to-back operands against a plain-arithmetic trunc(A/B) model.
module tb_div_32;
    logic clock;
    logic reset_n;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] last_res;
    logic        last_exc;
    logic        rdy_prev;

    div_32_if bus();

    div_32 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got 0x%08h, required 0x%08h", name, cyc, act, req);
        end
    endtask

    // Truncating signed division on 64-bit integers; divide-by-zero gives {exc=1, 0}.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (sb == 0)
            return {1'b1, 32'd0};
        q = sa / sb;
        return {1'b0, q[31:0]};
    endfunction

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic issue_exp(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] res, input logic exc, input bit hold);
        exp_t n;
        n.res = res;
        n.exc = exc;
        n.cyc = cyc + 35;
        exp_q.delete();
        exp_q.push_back(n);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        step();
        if (!hold) begin
            bus.ctrl_DIV      = 1'b0;
            bus.data_operandA = $urandom;
            bus.data_operandB = $urandom;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] m;
        m = model(a, b);
        issue_exp(a, b, m[31:0], m[32], 1'b0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++)
            step();
        if (exp_q.size() > 0) begin
            nvec++;
            nerr++;
            $display("FAIL wait_timeout: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: samples on the falling edge; stimulus always acts 1ns later.
    initial begin
        rdy_prev = 1'b0;
        last_res = '0;
        last_exc = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                last_res = '0;
                last_exc = 1'b0;
                rdy_prev = 1'b0;
            end else begin
                if (bus.data_resultRDY) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", {31'd0, bus.data_resultRDY}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", bus.data_result, e.res);
                        chk("exception", {31'd0, bus.data_exception}, {31'd0, e.exc});
                        chk("strobe_cycle", cyc, e.cyc);
                        chk("busy_at_strobe", {31'd0, bus.data_busy}, 32'd0);
                    end
                    chk("strobe_width", {31'd0, rdy_prev}, 32'd0);
                    last_res = bus.data_result;
                    last_exc = bus.data_exception;
                end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
                    chk("missing_strobe", {31'd0, bus.data_resultRDY}, 32'd1);
                    exp_q.delete(0);
                end else begin
                    if (exp_q.size() > 0)
                        chk("busy_inflight", {31'd0, bus.data_busy}, 32'd1);
                    else
                        chk("busy_idle", {31'd0, bus.data_busy}, 32'd0);
                    if (exp_q.size() == 0 || cyc < exp_q[0].cyc - 1) begin
                        chk("result_stable", bus.data_result, last_res);
                        chk("exception_stable", {31'd0, bus.data_exception}, {31'd0, last_exc});
                    end
                end
                rdy_prev = bus.data_resultRDY;
            end
        end
    end

    initial begin
        reset_n           = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) step();
        chk("reset_result", bus.data_result, 32'd0);
        chk("reset_exception", {31'd0, bus.data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        chk("reset_busy", {31'd0, bus.data_busy}, 32'd0);
        reset_n = 1'b1;
        repeat (2) step();

        // Directed: signs, divide-by-zero and recovery, edge values (back-to-back).
        issue_exp(32'd100, 32'd7, 32'h0000000E, 1'b0, 1'b0);          wait_done();
        issue_exp(-32'sd100, 32'd7, 32'hFFFFFFF2, 1'b0, 1'b0);        wait_done();
        issue_exp(-32'sd100, -32'sd7, 32'h0000000E, 1'b0, 1'b0);      wait_done();
        issue_exp(32'd7, 32'd0, 32'h00000000, 1'b1, 1'b0);            wait_done();
        issue_exp(32'd12, 32'd4, 32'h00000003, 1'b0, 1'b0);           wait_done();
        issue_exp(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0); wait_done();
        issue_exp(32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b0);     wait_done();
        issue_exp(32'd5, 32'd9, 32'h00000000, 1'b0, 1'b0);            wait_done();
        issue_exp(32'd0, -32'sd3, 32'h00000000, 1'b0, 1'b0);          wait_done();

        // Restart mid-run: only the second operation may strobe.
        repeat (3) step();
        issue_exp(32'd100, 32'd7, 32'h0000000E, 1'b0, 1'b0);
        repeat (9) step();
        issue_exp(32'd81, 32'd9, 32'h00000009, 1'b0, 1'b0);
        wait_done();

        // Asynchronous reset in the middle of a clock high phase.
        repeat (2) step();
        issue_exp(32'd100, 32'd7, 32'h0000000E, 1'b0, 1'b0);
        repeat (14) step();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset_result", bus.data_result, 32'd0);
        chk("async_reset_exception", {31'd0, bus.data_exception}, 32'd0);
        chk("async_reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        chk("async_reset_busy", {31'd0, bus.data_busy}, 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        repeat (40) step();
        issue_exp(32'd50, 32'd5, 32'h0000000A, 1'b0, 1'b0);
        wait_done();

        // Start held high: restarts every edge, completes only after release.
        for (int i = 0; i < 40; i++)
            issue_exp(32'd9, 32'd3, 32'h00000003, 1'b0, 1'b1);
        bus.ctrl_DIV = 1'b0;
        wait_done();

        // Random back-to-back operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 20)) - 32'd10;
                1:       b = $urandom >> $urandom_range(0, 31);
                2:       begin a = a >>> $urandom_range(0, 24); b = $urandom; end
                default: b = $urandom;
            endcase
            issue(a, b);
            wait_done();
        end

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
